// File: rtl/reg_file.sv
// General-purpose register file: 2^ADSize words, two combinational read ports,
// one synchronous write port, contents cleared asynchronously on reset.
module reg_file #(
  parameter int ADSize  = 5,
  parameter int REGSize = 32,
  parameter int DASize  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Write,
  input  logic [ADSize-1:0] Write_ADDR,
  input  logic [DASize-1:0] DIN,
  input  logic [ADSize-1:0] Read_ADDR_1,
  input  logic [ADSize-1:0] Read_ADDR_2,
  output logic [DASize-1:0] OUT_1,
  output logic [DASize-1:0] OUT_2
);

  logic [DASize-1:0] mem [REGSize];

  // Reset wins over a coincident write edge; address 0 is an ordinary register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGSize; i++) begin
        mem[i] <= '0;
      end
    end else if (Write) begin
      mem[Write_ADDR] <= DIN;
    end
  end

  // No write-to-read bypass: reads see the stored value only.
  always_comb begin
    OUT_1 = mem[Read_ADDR_1];
    OUT_2 = mem[Read_ADDR_2];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// checked against an array model of the register contents.
module tb_reg_file;

  localparam int AW = 5;
  localparam int NW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          Write;
  logic [AW-1:0] Write_ADDR;
  logic [DW-1:0] DIN;
  logic [AW-1:0] Read_ADDR_1;
  logic [AW-1:0] Read_ADDR_2;
  logic [DW-1:0] OUT_1;
  logic [DW-1:0] OUT_2;

  logic [DW-1:0] refMem [NW];
  int checkCount = 0;
  int failCount  = 0;

  reg_file #(.ADSize(AW), .REGSize(NW), .DASize(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .Write      (Write),
    .Write_ADDR (Write_ADDR),
    .DIN        (DIN),
    .Read_ADDR_1(Read_ADDR_1),
    .Read_ADDR_2(Read_ADDR_2),
    .OUT_1      (OUT_1),
    .OUT_2      (OUT_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive all inputs just after a falling edge, then let reads settle.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] d, input logic [AW-1:0] r1,
                               input logic [AW-1:0] r2);
    @(negedge clk);
    Write       = we;
    Write_ADDR  = wa;
    DIN         = d;
    Read_ADDR_1 = r1;
    Read_ADDR_2 = r2;
    #1;
  endtask

  // Advance through one rising edge and apply the write rule to the model.
  task automatic stepCycle();
    @(posedge clk);
    if (!rst && Write) refMem[Write_ADDR] = DIN;
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < NW; i++) refMem[i] = '0;
  endtask

  task automatic checkReads(input string tag);
    checkOutput({tag, "_out1"}, OUT_1, refMem[Read_ADDR_1]);
    checkOutput({tag, "_out2"}, OUT_2, refMem[Read_ADDR_2]);
  endtask

  typedef struct {
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } readVec_t;

  readVec_t readTab [4];

  initial begin
    readTab[0] = '{5'd1, 5'd4, 32'd2, 32'd0};
    readTab[1] = '{5'd3, 5'd2, 32'd4, 32'd3};
    readTab[2] = '{5'd2, 5'd3, 32'd3, 32'd4};
    readTab[3] = '{5'd4, 5'd1, 32'd0, 32'd2};

    rst = 1'b1; Write = 1'b0; Write_ADDR = '0; DIN = '0;
    Read_ADDR_1 = '0; Read_ADDR_2 = '0;
    clearModel();
    #3;
    checkOutput("reset_out1", OUT_1, 32'd0);
    checkOutput("reset_out2", OUT_2, 32'd0);
    for (int i = 0; i < NW; i++) checkOutput($sformatf("reset_mem%0d", i), dut.mem[i], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stepCycle();
    for (int i = 0; i < NW; i++) checkOutput($sformatf("postrst_mem%0d", i), dut.mem[i], 32'd0);

    // Sequential writes (0,1),(1,2),(2,3),(3,4) while reading addresses 1 and 2.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, AW'(k), DW'(k + 1), 5'd1, 5'd2);
      stepCycle();
      checkOutput($sformatf("seq%0d_out1", k), OUT_1, (k >= 1) ? 32'd2 : 32'd0);
      checkOutput($sformatf("seq%0d_out2", k), OUT_2, (k >= 2) ? 32'd3 : 32'd0);
    end

    // Readback with writes disabled; DIN=0xF must never land.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 5'd0, 32'hF, readTab[k].r1, readTab[k].r2);
      checkOutput($sformatf("rb%0d_out1", k), OUT_1, readTab[k].e1);
      checkOutput($sformatf("rb%0d_out2", k), OUT_2, readTab[k].e2);
      stepCycle();
    end
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rb_mem%0d", i), dut.mem[i], DW'(i + 1));

    // Same-address read/write: old value before the edge, new value after.
    applyStimulus(1'b1, 5'd5, 32'hA, 5'd5, 5'd0);
    stepCycle();
    applyStimulus(1'b1, 5'd5, 32'hB, 5'd5, 5'd5);
    checkOutput("same_pre_out1", OUT_1, 32'hA);
    checkOutput("same_pre_out2", OUT_2, 32'hA);
    stepCycle();
    checkOutput("same_post_out1", OUT_1, 32'hB);
    checkOutput("same_post_out2", OUT_2, 32'hB);

    // Randomized traffic against the model, reads checked before and after each edge.
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                    AW'($urandom), AW'($urandom));
      checkReads($sformatf("rnd%0d_pre", n));
      stepCycle();
      checkReads($sformatf("rnd%0d_post", n));
    end

    // Async reset between edges, then held across an edge with Write=1.
    applyStimulus(1'b1, 5'd0, 32'h1, 5'd0, 5'd1);
    stepCycle();
    applyStimulus(1'b1, 5'd1, 32'h2, 5'd0, 5'd1);
    stepCycle();
    applyStimulus(1'b1, 5'd7, 32'h55, 5'd0, 5'd1);
    checkOutput("prerst_out1", OUT_1, 32'h1);
    checkOutput("prerst_out2", OUT_2, 32'h2);
    rst = 1'b1;
    clearModel();
    #1;
    checkOutput("asyncrst_out1", OUT_1, 32'd0);
    checkOutput("asyncrst_out2", OUT_2, 32'd0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("asyncrst_mem%0d", i), dut.mem[i], 32'd0);
    stepCycle();
    checkOutput("rstedge_mem7", dut.mem[7], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    Write = 1'b0;
    #1;
    checkReads("rstrel");

    // Extremes: all-ones at the top address, address 0 keeps its own value.
    applyStimulus(1'b1, 5'd0, 32'h1234_5678, 5'd31, 5'd31);
    stepCycle();
    applyStimulus(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd31);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
    checkOutput("ext_out1", OUT_1, 32'hFFFF_FFFF);
    checkOutput("ext_out2", OUT_2, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd31);
    checkOutput("ext_addr0", OUT_1, 32'h1234_5678);
    checkReads("ext_model");

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
